// File: rtl/vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// vga_write_arbiter
//
// Purpose: shares the VGA adapter pixel-write port between four drawing
// engines (0 floor/erase, 1 obstacle, 2 running man, 3 game-over overlay).
// An engine raises req, is granted a burst, streams pixels over a
// valid/ready handshake and flags its final pixel with last. Bursts are
// serialised and one pixel per cycle is registered onto the adapter's
// x/y/colour/plot inputs.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   req_i[3:0]           burst request per engine
//   pix_valid_i[3:0]     engine i is presenting a pixel
//   pix_last_i[3:0]      presented pixel is the last of the burst
//   pix_x_i/pix_y_i/pix_col_i  packed per-engine coordinates and colour
//   gnt_o[3:0]           registered one-hot grant
//   pix_ready_o[3:0]     pixel accepted this cycle (combinational)
//   vga_x_o/vga_y_o/vga_colour_o/vga_plot_o  registered adapter write port
//   busy_o               high while a burst is in progress
//   burst_done_o[3:0]    one-cycle pulse when engine i's burst ends on last
//   timeout_o            one-cycle pulse when a burst is cut at MAX_BURST
// ---------------------------------------------------------------------------
module vga_write_arbiter #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3,
    parameter int MAX_BURST = 19200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req_i,
    input  logic [3:0]       pix_valid_i,
    input  logic [3:0]       pix_last_i,
    input  logic [4*X_W-1:0] pix_x_i,
    input  logic [4*Y_W-1:0] pix_y_i,
    input  logic [4*C_W-1:0] pix_col_i,
    output logic [3:0]       gnt_o,
    output logic [3:0]       pix_ready_o,
    output logic [X_W-1:0]   vga_x_o,
    output logic [Y_W-1:0]   vga_y_o,
    output logic [C_W-1:0]   vga_colour_o,
    output logic             vga_plot_o,
    output logic             busy_o,
    output logic [3:0]       burst_done_o,
    output logic             timeout_o
);

    localparam int                CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CAP   = CNT_W'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       rr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [X_W-1:0]   vga_x_q;
    logic [Y_W-1:0]   vga_y_q;
    logic [C_W-1:0]   vga_colour_q;
    logic             vga_plot_q;
    logic [3:0]       burst_done_q;
    logic             timeout_q;

    // Per-engine views of the packed pixel buses.
    logic [X_W-1:0] x_arr   [4];
    logic [Y_W-1:0] y_arr   [4];
    logic [C_W-1:0] col_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign x_arr[gi]   = pix_x_i[gi*X_W +: X_W];
            assign y_arr[gi]   = pix_y_i[gi*Y_W +: Y_W];
            assign col_arr[gi] = pix_col_i[gi*C_W +: C_W];
        end
    endgenerate

    // Round-robin search order for engines 0-2: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
    logic [1:0] rr_cand [3];
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rr_cand
            logic [2:0] sum;
            assign sum          = {1'b0, rr_ptr_q} + 3'(gi);
            assign rr_cand[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        end
    endgenerate

    // Winner for a new burst. Engine 3 always wins; otherwise the first
    // requester in round-robin order. Scanning from the back lets the
    // earliest candidate overwrite the later ones.
    logic [1:0] win_idx;
    always_comb begin
        win_idx = 2'd3;
        if (!req_i[3]) begin
            win_idx = rr_cand[0];
            for (int k = 2; k >= 0; k--) begin
                if (req_i[rr_cand[k]]) begin
                    win_idx = rr_cand[k];
                end
            end
        end
    end

    // Index of the currently granted engine.
    logic [1:0] g_idx;
    always_comb begin
        case (gnt_q)
            4'b0010: g_idx = 2'd1;
            4'b0100: g_idx = 2'd2;
            4'b1000: g_idx = 2'd3;
            default: g_idx = 2'd0;
        endcase
    end

    logic             in_burst;
    logic             accept;
    logic             sel_last;
    logic             sel_req;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit_cap;
    logic             end_burst;
    logic [1:0]       rr_after;

    assign in_burst  = (state_q == BURST);
    assign accept    = in_burst && pix_valid_i[g_idx];
    assign sel_last  = pix_last_i[g_idx];
    assign sel_req   = req_i[g_idx];
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign hit_cap   = (cnt_inc == CAP);
    // A burst ends on an accepted last pixel, on reaching the cap, or when
    // the owner withdraws its request without finishing (abort).
    assign end_burst = in_burst && (accept ? (sel_last || hit_cap || !sel_req) : !sel_req);
    assign rr_after  = (g_idx == 2'd2) ? 2'd0 : 2'(g_idx + 2'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gnt_q        <= 4'b0;
            rr_ptr_q     <= 2'd0;
            cnt_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            burst_done_q <= 4'b0;
            timeout_q    <= 1'b0;
        end else begin
            vga_plot_q   <= 1'b0;
            burst_done_q <= 4'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        gnt_q   <= 4'b0001 << win_idx;
                        cnt_q   <= '0;
                        state_q <= BURST;
                    end else begin
                        gnt_q   <= 4'b0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        vga_x_q      <= x_arr[g_idx];
                        vga_y_q      <= y_arr[g_idx];
                        vga_colour_q <= col_arr[g_idx];
                        vga_plot_q   <= 1'b1;
                        cnt_q        <= cnt_inc;
                    end
                    // Last takes precedence over the cap when both coincide.
                    if (accept && sel_last) begin
                        burst_done_q <= gnt_q;
                    end else if (accept && hit_cap) begin
                        timeout_q    <= 1'b1;
                    end
                    if (end_burst) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0;
                        // The overlay engine does not take part in the rotation.
                        if (g_idx != 2'd3) begin
                            rr_ptr_q <= rr_after;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign pix_ready_o  = in_burst ? (gnt_q & pix_valid_i) : 4'b0;
    assign vga_x_o      = vga_x_q;
    assign vga_y_o      = vga_y_q;
    assign vga_colour_o = vga_colour_q;
    assign vga_plot_o   = vga_plot_q;
    assign busy_o       = in_burst;
    assign burst_done_o = burst_done_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_write_arbiter
//
// Directed scenarios plus a randomized run, all checked against a small
// transaction-level model of the arbiter: an owner index (or -1 when idle),
// a pixel count for the current burst and the round-robin pointer.
// The cap is set to 4 so the timeout path is reachable quickly.
// ---------------------------------------------------------------------------
module tb_vga_write_arbiter;

    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int C_W  = 3;
    localparam int MAXB = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       req;
    logic [3:0]       pix_valid;
    logic [3:0]       pix_last;
    logic [4*X_W-1:0] pix_x;
    logic [4*Y_W-1:0] pix_y;
    logic [4*C_W-1:0] pix_col;
    logic [3:0]       gnt;
    logic [3:0]       pix_ready;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [C_W-1:0]   vga_colour;
    logic             vga_plot;
    logic             busy;
    logic [3:0]       burst_done;
    logic             timeout;

    always #5 clk = ~clk;

    vga_write_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_i(req), .pix_valid_i(pix_valid), .pix_last_i(pix_last),
        .pix_x_i(pix_x), .pix_y_i(pix_y), .pix_col_i(pix_col),
        .gnt_o(gnt), .pix_ready_o(pix_ready),
        .vga_x_o(vga_x), .vga_y_o(vga_y), .vga_colour_o(vga_colour), .vga_plot_o(vga_plot),
        .busy_o(busy), .burst_done_o(burst_done), .timeout_o(timeout)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int             m_owner = -1;
    int             m_count = 0;
    int             m_rr    = 0;
    logic [3:0]     m_gnt   = 4'b0;
    logic [3:0]     m_done  = 4'b0;
    logic [X_W-1:0] m_x     = '0;
    logic [Y_W-1:0] m_y     = '0;
    logic [C_W-1:0] m_c     = '0;
    logic           m_plot  = 1'b0;
    logic           m_to    = 1'b0;
    logic           m_busy  = 1'b0;

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        r = 4'b0;
        if (m_owner >= 0) begin
            if (pix_valid[m_owner]) r = 4'(1 << m_owner);
        end
        return r;
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v == 4'(1 << i)) r = i;
        return r;
    endfunction

    // Advance one clock: evaluate the model on the inputs as seen at the
    // edge, then return 1 time unit after the edge.
    task automatic step();
        int n_owner, n_count, n_rr, o, w;
        logic [3:0] n_done;
        logic n_plot, n_to, fin;
        logic [X_W-1:0] n_x;
        logic [Y_W-1:0] n_y;
        logic [C_W-1:0] n_c;
        @(negedge clk);
        n_owner = m_owner; n_count = m_count; n_rr = m_rr;
        n_x = m_x; n_y = m_y; n_c = m_c;
        n_plot = 1'b0; n_done = 4'b0; n_to = 1'b0;
        if (!reset_n) begin
            n_owner = -1; n_count = 0; n_rr = 0; n_x = '0; n_y = '0; n_c = '0;
        end else if (m_owner < 0) begin
            if (req != 4'b0) begin
                w = -1;
                if (req[3]) w = 3;
                else for (int k = 0; k < 3; k++) if (w < 0 && req[(m_rr + k) % 3]) w = (m_rr + k) % 3;
                n_owner = w; n_count = 0;
            end
        end else begin
            o = m_owner; fin = 1'b0;
            if (pix_valid[o]) begin
                n_x = pix_x[o*X_W +: X_W]; n_y = pix_y[o*Y_W +: Y_W]; n_c = pix_col[o*C_W +: C_W];
                n_plot = 1'b1; n_count = m_count + 1;
                if (pix_last[o]) begin n_done[o] = 1'b1; fin = 1'b1; end
                else if (n_count == MAXB) begin n_to = 1'b1; fin = 1'b1; end
                else if (!req[o]) fin = 1'b1;
            end else if (!req[o]) fin = 1'b1;
            if (fin) begin
                n_owner = -1;
                if (o < 3) n_rr = (o + 1) % 3;
            end
        end
        @(posedge clk);
        m_owner = n_owner; m_count = n_count; m_rr = n_rr;
        m_x = n_x; m_y = n_y; m_c = n_c; m_plot = n_plot; m_done = n_done; m_to = n_to;
        m_gnt  = (n_owner >= 0) ? 4'(1 << n_owner) : 4'b0;
        m_busy = (n_owner >= 0);
        #1;
    endtask

    task automatic set_pix(input int e, input logic v, input logic l,
                           input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic [C_W-1:0] c);
        pix_valid[e] = v;
        pix_last[e]  = l;
        pix_x[e*X_W +: X_W] = x;
        pix_y[e*Y_W +: Y_W] = y;
        pix_col[e*C_W +: C_W] = c;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; req = 4'b0; pix_valid = 4'b0; pix_last = 4'b0;
        pix_x = '0; pix_y = '0; pix_col = '0;
        step(); step();
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (pix_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", pix_ready); end
        total++; if ({vga_x, vga_y, vga_colour} !== '0) begin bad++; $display("FAIL reset_coords got=%0d/%0d/%0d want=0/0/0", vga_x, vga_y, vga_colour); end
        total++; if ({vga_plot, busy, timeout} !== 3'b0) begin bad++; $display("FAIL reset_flags got plot=%b busy=%b to=%b want 0", vga_plot, busy, timeout); end
        total++; if (burst_done !== 4'b0) begin bad++; $display("FAIL reset_done got=%b want=0000", burst_done); end
        total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL reset_rr got=%0d want=0", dut.rr_ptr_q); end
        reset_n = 1'b1;
        step();
        $display("reset: gnt=%b plot=%b busy=%b", gnt, vga_plot, busy);
    endtask

    task automatic test_single_burst();
        req = 4'b0100;
        set_pix(2, 1'b1, 1'b0, 8'd20, 7'd40, 3'd5);
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
        total++; if (vga_plot !== 1'b0) begin bad++; $display("FAIL single_plot_early got=%b want=0", vga_plot); end
        for (int p = 0; p < 3; p++) begin
            set_pix(2, 1'b1, (p == 2), 8'(20 + p), 7'd40, 3'd5);
            #1;
            total++; if (pix_ready !== 4'b0100) begin bad++; $display("FAIL single_ready p=%0d got=%b want=0100", p, pix_ready); end
            step();
            total++; if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'(20 + p), 7'd40, 3'd5})
                begin bad++; $display("FAIL single_pix p=%0d got=%b,%0d,%0d,%0d want=1,%0d,40,5", p, vga_plot, vga_x, vga_y, vga_colour, 20 + p); end
            total++; if (burst_done !== ((p == 2) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL single_done p=%0d got=%b", p, burst_done); end
            $display("single: pixel %0d plotted at (%0d,%0d) done=%b", p, vga_x, vga_y, burst_done);
        end
        total++; if ({gnt, busy} !== 5'b0) begin bad++; $display("FAIL single_gap got gnt=%b busy=%b want 0000/0", gnt, busy); end
        set_pix(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_regrant got=%b want=0100", gnt); end
        total++; if (burst_done !== 4'b0) begin bad++; $display("FAIL single_done_width got=%b want=0000", burst_done); end
        req = 4'b0;
        step();
        total++; if ({gnt, burst_done} !== 8'b0) begin bad++; $display("FAIL single_abort got gnt=%b done=%b want 0", gnt, burst_done); end
        step();
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[4] = '{0, 1, 2, 0};
        int bc;
        logic [3:0] r, prev;
        bit rr_checked;
        bc = 0; prev = 4'b0; rr_checked = 0;
        req = 4'b0111; pix_valid = 4'b0111; pix_last = 4'b0;
        for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
            pix_last = (bc == 1) ? 4'b0111 : 4'b0000;
            #1; r = pix_ready;
            step();
            if (r != 4'b0) bc++;
            if (gnt == 4'b0) bc = 0;
            total++; if (gnt !== m_gnt) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", cyc, gnt, m_gnt); end
            if (burst_done != 4'b0 && !rr_checked) begin
                rr_checked = 1;
                total++; if (dut.rr_ptr_q !== 2'd1) begin bad++; $display("FAIL rr_ptr_after_first got=%0d want=1", dut.rr_ptr_q); end
            end
            if (gnt != 4'b0 && prev == 4'b0) begin
                order.push_back(onehot_idx(gnt));
                $display("round_robin: grant to engine %0d", onehot_idx(gnt));
            end
            prev = gnt;
        end
        total++; if (order.size() != 4) begin bad++; $display("FAIL rr_count got=%0d want=4", order.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) begin
                total++; if (order[i] != exp_order[i]) begin bad++; $display("FAIL rr_order i=%0d got=%0d want=%0d", i, order[i], exp_order[i]); end
            end
        end
        req = 4'b0; pix_valid = 4'b0; pix_last = 4'b0;
        step(); step();
    endtask

    task automatic test_priority();
        int order[$];
        int exp_order[3] = '{0, 3, 1};
        int bc;
        logic [3:0] r, prev;
        bit raised;
        bc = 0; prev = 4'b0; raised = 0;
        req = 4'b0001; pix_valid = 4'b1111; pix_last = 4'b0;
        for (int cyc = 0; cyc < 80 && (req != 4'b0 || gnt != 4'b0 || cyc == 0); cyc++) begin
            pix_last = (bc == 2) ? 4'b1111 : 4'b0000;
            #1; r = pix_ready;
            step();
            if (r != 4'b0) bc++;
            if (gnt == 4'b0) bc = 0;
            req = req & ~burst_done;
            total++; if (gnt !== m_gnt) begin bad++; $display("FAIL prio_gnt cyc=%0d got=%b want=%b", cyc, gnt, m_gnt); end
            if (gnt != 4'b0 && prev == 4'b0) begin
                order.push_back(onehot_idx(gnt));
                $display("priority: grant to engine %0d", onehot_idx(gnt));
            end
            if (order.size() == 1 && bc == 1 && !raised) begin
                raised = 1;
                req = req | 4'b1010;
            end
            prev = gnt;
        end
        total++; if (order.size() != 3) begin bad++; $display("FAIL prio_count got=%0d want=3", order.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < order.size()) begin
                total++; if (order[i] != exp_order[i]) begin bad++; $display("FAIL prio_order i=%0d got=%0d want=%0d", i, order[i], exp_order[i]); end
            end
        end
        total++; if (dut.rr_ptr_q !== 2'd2) begin bad++; $display("FAIL prio_rr got=%0d want=2", dut.rr_ptr_q); end
        req = 4'b0; pix_valid = 4'b0; pix_last = 4'b0;
        step();
    endtask

    task automatic test_stall_abort();
        req = 4'b0010;
        set_pix(1, 1'b1, 1'b0, 8'd50, 7'd60, 3'd2);
        step();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_gnt got=%b want=0010", gnt); end
        step();
        set_pix(1, 1'b1, 1'b0, 8'd51, 7'd61, 3'd3);
        step();
        total++; if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd51, 7'd61}) begin bad++; $display("FAIL stall_second got=%b,%0d,%0d want=1,51,61", vga_plot, vga_x, vga_y); end
        set_pix(1, 1'b0, 1'b1, 8'd99, 7'd99, 3'd7);
        for (int s = 0; s < 4; s++) begin
            step();
            total++; if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b0, 8'd51, 7'd61, 3'd3})
                begin bad++; $display("FAIL stall_hold s=%0d got=%b,%0d,%0d,%0d want=0,51,61,3", s, vga_plot, vga_x, vga_y, vga_colour); end
            total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_keep s=%0d got=%b want=0010", s, gnt); end
            $display("stall: cycle %0d plot=%b x=%0d", s, vga_plot, vga_x);
        end
        req = 4'b0;
        step();
        total++; if ({gnt, busy, burst_done} !== 9'b0) begin bad++; $display("FAIL abort got gnt=%b busy=%b done=%b want 0", gnt, busy, burst_done); end
        total++; if (dut.rr_ptr_q !== 2'd2) begin bad++; $display("FAIL abort_rr got=%0d want=2", dut.rr_ptr_q); end
        set_pix(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        step();
    endtask

    task automatic test_cap();
        int plots;
        bit saw_to;
        plots = 0; saw_to = 0;
        req = 4'b0001;
        set_pix(0, 1'b1, 1'b0, 8'd10, 7'd5, 3'd1);
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL cap_gnt got=%b want=0001", gnt); end
        for (int k = 0; k < 10 && !saw_to; k++) begin
            set_pix(0, 1'b1, 1'b0, 8'(10 + k), 7'd5, 3'd1);
            step();
            if (vga_plot) plots++;
            if (timeout) begin
                saw_to = 1;
                total++; if ({gnt, burst_done} !== 8'b0) begin bad++; $display("FAIL cap_end got gnt=%b done=%b want 0", gnt, burst_done); end
            end
        end
        $display("cap: plots=%0d timeout_seen=%0d", plots, saw_to);
        total++; if (plots != MAXB) begin bad++; $display("FAIL cap_plots got=%0d want=%0d", plots, MAXB); end
        total++; if (!saw_to) begin bad++; $display("FAIL cap_timeout got=0 want=1"); end
        req = 4'b0; pix_valid = 4'b0;
        step();
        total++; if ({gnt, timeout} !== 5'b0) begin bad++; $display("FAIL cap_after got gnt=%b to=%b want 0", gnt, timeout); end
    endtask

    task automatic test_reset_mid_burst();
        req = 4'b0100;
        set_pix(2, 1'b1, 1'b0, 8'd70, 7'd80, 3'd6);
        step();
        step();
        total++; if (vga_plot !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b want=1", vga_plot); end
        reset_n = 1'b0;
        step();
        total++; if ({gnt, pix_ready, burst_done} !== 12'b0) begin bad++; $display("FAIL rst_mid_vec got gnt=%b rdy=%b done=%b want 0", gnt, pix_ready, burst_done); end
        total++; if ({vga_x, vga_y, vga_colour, vga_plot, busy, timeout} !== '0) begin bad++; $display("FAIL rst_mid_out got x=%0d y=%0d c=%0d plot=%b busy=%b to=%b want 0", vga_x, vga_y, vga_colour, vga_plot, busy, timeout); end
        total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL rst_mid_rr got=%0d want=0", dut.rr_ptr_q); end
        reset_n = 1'b1;
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rst_mid_regrant got=%b want=0100", gnt); end
        set_pix(2, 1'b1, 1'b1, 8'd71, 7'd81, 3'd6);
        step();
        total++; if ({burst_done, vga_plot, vga_x} !== {4'b0100, 1'b1, 8'd71}) begin bad++; $display("FAIL rst_mid_done got done=%b plot=%b x=%0d want 0100,1,71", burst_done, vga_plot, vga_x); end
        $display("reset_mid_burst: regrant=%b done=%b", 4'b0100, burst_done);
        req = 4'b0; pix_valid = 4'b0; pix_last = 4'b0;
        step();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset_n = ($urandom_range(0, 149) != 0);
            for (int e = 0; e < 4; e++) begin
                if ($urandom_range(0, (e == 3) ? 29 : 7) == 0) req[e] = ~req[e];
                set_pix(e, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                        X_W'($urandom), Y_W'($urandom), C_W'($urandom));
            end
            #1;
            total++; if (pix_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, pix_ready, m_ready()); end
            step();
            total++; if (gnt !== m_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", cyc, gnt, m_gnt); end
            total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, m_busy); end
            total++; if (vga_plot !== m_plot) begin bad++; $display("FAIL rnd_plot cyc=%0d got=%b want=%b", cyc, vga_plot, m_plot); end
            total++; if ({vga_x, vga_y, vga_colour} !== {m_x, m_y, m_c}) begin bad++; $display("FAIL rnd_pix cyc=%0d got=%0d,%0d,%0d want=%0d,%0d,%0d", cyc, vga_x, vga_y, vga_colour, m_x, m_y, m_c); end
            total++; if (burst_done !== m_done) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", cyc, burst_done, m_done); end
            total++; if (timeout !== m_to) begin bad++; $display("FAIL rnd_timeout cyc=%0d got=%b want=%b", cyc, timeout, m_to); end
            if (m_done != 4'b0 || m_to) $display("random: cyc=%0d burst end done=%b timeout=%b", cyc, burst_done, timeout);
        end
        reset_n = 1'b1; req = 4'b0; pix_valid = 4'b0; pix_last = 4'b0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_priority();
        test_stall_abort();
        test_cap();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_write_arbiter.md
# vga_write_arbiter

Shares the single VGA adapter pixel-write port between the four drawing engines: floor/erase, obstacle/tree, running man and game-over overlay. Each engine requests a burst, streams pixels under a valid/ready handshake and marks its final pixel. The arbiter serialises the bursts and registers one pixel per cycle onto the adapter's x/y/colour/plot inputs. It sits between the game FSM's drawing engines and the VGA adapter, and replaces direct writeEn muxing.

## Interface
- X_W, 8, x coordinate width (160-wide screen)
- Y_W, 7, y coordinate width (120-tall screen)
- C_W, 3, colour width
- MAX_BURST, 19200, pixel cap per burst (full 160x120 screen)
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req  in  4  burst request per engine: 0 floor/erase, 1 obstacle, 2 man, 3 game-over
- pix_valid  in  4  engine i is presenting a pixel
- pix_last  in  4  presented pixel is the final pixel of the burst
- pix_x  in  4*X_W  engine i x at [i*X_W +: X_W]
- pix_y  in  4*Y_W  engine i y at [i*Y_W +: Y_W]
- pix_col  in  4*C_W  engine i colour at [i*C_W +: C_W]
- gnt  out  4  registered one-hot grant
- pix_ready  out  4  pixel accepted this cycle
- vga_x  out  X_W  registered x to adapter
- vga_y  out  Y_W  registered y to adapter
- vga_colour  out  C_W  registered colour to adapter
- vga_plot  out  1  registered write enable to adapter
- busy  out  1  high while in BURST
- burst_done  out  4  one-cycle pulse when engine i's burst ends normally
- timeout  out  1  one-cycle pulse when a burst is force-ended at MAX_BURST

## Operation
- States: IDLE, BURST.
- IDLE:
  - If req is nonzero, choose a winner, load gnt, clear the pixel counter and go to BURST.
  - Otherwise stay in IDLE with gnt=0.
- Arbitration:
  - req[3] has strict highest priority.
  - Engines 0-2 are served round-robin. Search starts at rr_ptr, then rr_ptr+1, rr_ptr+2 (mod 3). rr_ptr resets to 0.
  - When a burst from engine i<3 ends, by any cause, rr_ptr becomes (i+1) mod 3.
  - A grant to engine 3 leaves rr_ptr unchanged.
  - There is no preemption mid-burst.
- BURST, granted engine g:
  - pix_ready[g] = pix_valid[g]. All other pix_ready bits are 0.
  - Accepted pixel: vga_x/y/colour are loaded from slice g, vga_plot is set to 1 for the next cycle, and the counter is incremented.
  - Accepted pixel with pix_last[g]: pulse burst_done[g], clear gnt, go to IDLE.
  - req[g] falls without an accepted last pixel: abort. Clear gnt and go to IDLE. No burst_done pulse.
  - Counter reaches MAX_BURST on an accepted pixel without last: pulse timeout, clear gnt, go to IDLE. No burst_done pulse.
  - If last and the cap coincide, last wins: burst_done pulses, timeout does not.
- Ignored inputs:
  - pix_valid and pix_last from non-granted engines.
  - pix_last without pix_valid.
- Hold behaviour: vga_x/y/colour hold their value when no pixel is accepted; vga_plot is then 0.
- Counter width: clog2(MAX_BURST+1). The counter never wraps.

## Timing
- Reset values: state IDLE, gnt=0, pix_ready=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, burst_done=0, timeout=0, rr_ptr=0, counter=0.
- Reset mid-burst: all of the above reset values apply at the next edge. No burst_done pulse is issued, and any pending vga_plot is dropped.
- Handshake timing:
  - req seen in IDLE at edge t gives gnt at t+1.
  - The first pixel can be accepted in cycle t+1.
  - vga_plot for that pixel is high in cycle t+2.
- Throughput: one pixel per cycle inside a burst.
- Gap between bursts:
  - The last pixel is accepted in cycle n.
  - In cycle n+1: IDLE, gnt=0, burst_done high.
  - The next gnt is asserted in cycle n+2.
- burst_done and timeout are high for exactly the cycle after the terminating edge.
- pix_ready is combinational from state, gnt and pix_valid. There is no combinational path from req to gnt.

## Test plan
- Single burst: req[2] and 3 valid pixels (20,40,c5), (21,40,c5), (22,40,c5), with last on the 3rd. Expect gnt=0100 at t+1, vga_plot high for 3 consecutive cycles from t+2 with matching coordinates, burst_done[2] one pulse, one idle cycle before any new gnt.
- Round-robin: req[0..2] held high, each burst 2 pixels. Expect grant order 0,1,2,0, with rr_ptr=1 after the first burst.
- Priority: req[3] rises during engine 0's burst. Expect engine 0 to finish, then gnt=1000 even though req[1] is also pending, then engine 1.
- Stall and abort: engine 1 deasserts pix_valid for 4 cycles mid-burst. Expect vga_plot=0 and coordinates held. Then req[1] drops without last: expect IDLE, no burst_done, rr_ptr=2.
- Cap: MAX_BURST=4, engine 0 streams 6 pixels with no last. Expect exactly 4 plots, timeout pulse, gnt cleared.
- Reset mid-burst: reset_n low for one cycle during a burst. Expect all outputs at their reset values on the next edge. A fresh req[2] then grants 2 normally.
